// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse packet path.
package mouse_pkg;

    // Packet assembly states.
    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2,
        APPLY   = 2'd3
    } mouse_state_e;

    // Bit positions inside the status (first) byte of a packet.
    localparam int unsigned MB_LEFT    = 0;
    localparam int unsigned MB_RIGHT   = 1;
    localparam int unsigned MB_MIDDLE  = 2;
    localparam int unsigned MB_ALWAYS1 = 3;
    localparam int unsigned MB_XSIGN   = 4;
    localparam int unsigned MB_YSIGN   = 5;
    localparam int unsigned MB_XOVF    = 6;
    localparam int unsigned MB_YOVF    = 7;

    // Default screen extents (640x480).
    localparam int unsigned MOUSE_X_MAX = 639;
    localparam int unsigned MOUSE_Y_MAX = 479;

endpackage

// File: rtl/ps2_mouse_axis_acc.sv
// One coordinate axis: sign-extends the 9-bit PS/2 delta, masks it on
// overflow, adds or subtracts it from the current position and clamps the
// result to [0, MAX]. Purely combinational; the caller owns the register.
module ps2_mouse_axis_acc #(
    parameter int unsigned POS_WIDTH = 10,
    parameter int unsigned MAX       = 639,
    parameter bit          SUBTRACT  = 1'b0
) (
    input  logic [POS_WIDTH-1:0] pos_i,
    input  logic [7:0]           delta_i,
    input  logic                 sign_i,
    input  logic                 ovf_i,
    output logic [POS_WIDTH-1:0] pos_o
);

    // Two extra bits: one for sign, one for headroom above 2^POS_WIDTH.
    localparam int unsigned SUM_W = POS_WIDTH + 2;
    localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(MAX);

    logic signed [SUM_W-1:0] delta_s;
    logic signed [SUM_W-1:0] pos_s;
    logic signed [SUM_W-1:0] sum_s;

    // Extend, accumulate and clamp.
    always_comb begin
        delta_s = '0;
        if (!ovf_i) begin
            delta_s = {{(SUM_W-8){sign_i}}, delta_i};
        end
        pos_s = {2'b00, pos_i};
        sum_s = SUBTRACT ? (pos_s - delta_s) : (pos_s + delta_s);

        if (sum_s[SUM_W-1]) begin
            pos_o = '0;
        end else if (sum_s > MAX_S) begin
            pos_o = MAX_S[POS_WIDTH-1:0];
        end else begin
            pos_o = sum_s[POS_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/ps2_mouse_packet_decoder.sv
// Assembles PS/2 receiver bytes into 3-byte mouse packets, accumulates the
// movement into clamped absolute coordinates and latches button state.
module ps2_mouse_packet_decoder
    import mouse_pkg::*;
#(
    parameter int unsigned POS_WIDTH      = 10,
    parameter int unsigned X_MAX          = MOUSE_X_MAX,
    parameter int unsigned Y_MAX          = MOUSE_Y_MAX,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 rx_valid_i,
    input  logic [7:0]           rx_data_i,
    input  logic                 rx_err_i,
    input  logic                 ack_i,
    output logic [POS_WIDTH-1:0] x_pos_o,
    output logic [POS_WIDTH-1:0] y_pos_o,
    output logic [2:0]           buttons_o,
    output logic                 pos_valid_o,
    output logic [7:0]           drop_cnt_o
);

    localparam int unsigned     GAP_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYCLES);

    mouse_state_e state_q, state_d;

    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [7:0]           status_q, status_d;
    logic [7:0]           dx_q, dx_d;
    logic [7:0]           dy_q, dy_d;
    logic [POS_WIDTH-1:0] x_q, x_d;
    logic [POS_WIDTH-1:0] y_q, y_d;
    logic [2:0]           buttons_q, buttons_d;
    logic                 pos_valid_q, pos_valid_d;
    logic [7:0]           drop_q, drop_d;

    logic                 timeout;
    logic                 cap_status;
    logic                 cap_dx;
    logic                 cap_dy;
    logic                 apply_en;
    logic                 drop_en;
    logic                 gap_inc;
    logic [POS_WIDTH-1:0] x_next;
    logic [POS_WIDTH-1:0] y_next;

    assign timeout = (gap_q >= GAP_LIMIT);

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= WAIT_B0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an error strobe always beats a simultaneous byte.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_B0: begin
                if (!rx_err_i && rx_valid_i && rx_data_i[MB_ALWAYS1]) begin
                    state_d = WAIT_B1;
                end
            end
            WAIT_B1: begin
                if (rx_err_i || timeout) begin
                    state_d = WAIT_B0;
                end else if (rx_valid_i) begin
                    state_d = WAIT_B2;
                end
            end
            WAIT_B2: begin
                if (rx_err_i || timeout) begin
                    state_d = WAIT_B0;
                end else if (rx_valid_i) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                state_d = WAIT_B0;
            end
            default: begin
                state_d = WAIT_B0;
            end
        endcase
    end

    // Per-state control strobes for the datapath.
    always_comb begin
        cap_status = 1'b0;
        cap_dx     = 1'b0;
        cap_dy     = 1'b0;
        apply_en   = 1'b0;
        drop_en    = 1'b0;
        gap_inc    = 1'b0;
        unique case (state_q)
            WAIT_B0: begin
                if (rx_err_i) begin
                    drop_en = 1'b1;
                end else if (rx_valid_i) begin
                    if (rx_data_i[MB_ALWAYS1]) begin
                        cap_status = 1'b1;
                    end else begin
                        drop_en = 1'b1;
                    end
                end
            end
            WAIT_B1: begin
                if (rx_err_i || timeout) begin
                    drop_en = 1'b1;
                end else if (rx_valid_i) begin
                    cap_dx = 1'b1;
                end else begin
                    gap_inc = 1'b1;
                end
            end
            WAIT_B2: begin
                if (rx_err_i || timeout) begin
                    drop_en = 1'b1;
                end else if (rx_valid_i) begin
                    cap_dy = 1'b1;
                end else begin
                    gap_inc = 1'b1;
                end
            end
            APPLY: begin
                apply_en = 1'b1;
                // The receiver cannot legally deliver a byte this soon.
                drop_en  = rx_valid_i | rx_err_i;
            end
            default: begin
                drop_en = 1'b0;
            end
        endcase
    end

    ps2_mouse_axis_acc #(
        .POS_WIDTH (POS_WIDTH),
        .MAX       (X_MAX),
        .SUBTRACT  (1'b0)
    ) u_axis_x (
        .pos_i   (x_q),
        .delta_i (dx_q),
        .sign_i  (status_q[MB_XSIGN]),
        .ovf_i   (status_q[MB_XOVF]),
        .pos_o   (x_next)
    );

    // PS/2 reports +Y as up while screen Y grows downward, hence subtract.
    ps2_mouse_axis_acc #(
        .POS_WIDTH (POS_WIDTH),
        .MAX       (Y_MAX),
        .SUBTRACT  (1'b1)
    ) u_axis_y (
        .pos_i   (y_q),
        .delta_i (dy_q),
        .sign_i  (status_q[MB_YSIGN]),
        .ovf_i   (status_q[MB_YOVF]),
        .pos_o   (y_next)
    );

    // Datapath next-state: captures, position/button update, flags, counters.
    always_comb begin
        status_d    = cap_status ? rx_data_i : status_q;
        dx_d        = cap_dx ? rx_data_i : dx_q;
        dy_d        = cap_dy ? rx_data_i : dy_q;
        x_d         = apply_en ? x_next : x_q;
        y_d         = apply_en ? y_next : y_q;
        buttons_d   = apply_en ? {status_q[MB_MIDDLE], status_q[MB_RIGHT], status_q[MB_LEFT]}
                               : buttons_q;
        // Setting wins over a same-cycle ack.
        pos_valid_d = pos_valid_q;
        if (apply_en) begin
            pos_valid_d = 1'b1;
        end else if (ack_i) begin
            pos_valid_d = 1'b0;
        end
        drop_d = drop_q;
        if (drop_en && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
        // Cleared on accepted bytes, aborts and outside the mid-packet states.
        gap_d = gap_inc ? (gap_q + 1'b1) : '0;
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            gap_q       <= '0;
            status_q    <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            buttons_q   <= '0;
            pos_valid_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            gap_q       <= gap_d;
            status_q    <= status_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            x_q         <= x_d;
            y_q         <= y_d;
            buttons_q   <= buttons_d;
            pos_valid_q <= pos_valid_d;
            drop_q      <= drop_d;
        end
    end

    assign x_pos_o     = x_q;
    assign y_pos_o     = y_q;
    assign buttons_o   = buttons_q;
    assign pos_valid_o = pos_valid_q;
    assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// Self-checking bench for ps2_mouse_packet_decoder: a reference model pushes
// the expected coordinates/buttons per packet into a scoreboard queue and
// each scenario pops and compares when the update becomes visible.
module tb_ps2_mouse_packet_decoder;

    localparam int unsigned PW = 10;
    localparam int unsigned XM = 639;
    localparam int unsigned YM = 479;
    localparam int unsigned TO = 40;

    logic          clk_i      = 1'b0;
    logic          rstn_i     = 1'b0;
    logic          rx_valid_i = 1'b0;
    logic [7:0]    rx_data_i  = 8'h00;
    logic          rx_err_i   = 1'b0;
    logic          ack_i      = 1'b0;
    logic [PW-1:0] x_pos_o;
    logic [PW-1:0] y_pos_o;
    logic [2:0]    buttons_o;
    logic          pos_valid_o;
    logic [7:0]    drop_cnt_o;

    typedef struct {
        int         x;
        int         y;
        logic [2:0] b;
    } upd_t;

    upd_t sb[$];
    upd_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mx = 0;
    int   my = 0;
    int   exp_drop = 0;

    ps2_mouse_packet_decoder #(
        .POS_WIDTH      (PW),
        .X_MAX          (XM),
        .Y_MAX          (YM),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .rx_valid_i  (rx_valid_i),
        .rx_data_i   (rx_data_i),
        .rx_err_i    (rx_err_i),
        .ack_i       (ack_i),
        .x_pos_o     (x_pos_o),
        .y_pos_o     (y_pos_o),
        .buttons_o   (buttons_o),
        .pos_valid_o (pos_valid_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model of one applied packet; result goes to the scoreboard.
    task automatic model_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        int   dx;
        int   dy;
        upd_t u;
        dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
        dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
        mx = mx + dx;
        if (mx < 0) mx = 0;
        if (mx > int'(XM)) mx = int'(XM);
        my = my - dy;
        if (my < 0) my = 0;
        if (my > int'(YM)) my = int'(YM);
        u.x = mx;
        u.y = my;
        u.b = {b0[2], b0[1], b0[0]};
        sb.push_back(u);
    endtask

    // One-cycle byte strobe followed by 'idle' quiet cycles.
    task automatic send_byte(input logic [7:0] b, input int idle);
        @(negedge clk_i);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        repeat (idle) @(negedge clk_i);
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        model_packet(b0, b1, b2);
        send_byte(b0, 2);
        send_byte(b1, 2);
        send_byte(b2, 0);
    endtask

    task automatic pulse_ack();
        @(negedge clk_i);
        ack_i = 1'b1;
        @(negedge clk_i);
        ack_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rstn_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rstn_i   = 1'b1;
        mx       = 0;
        my       = 0;
        exp_drop = 0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({x_pos_o, y_pos_o, buttons_o, pos_valid_o, drop_cnt_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_values: got x=%0d y=%0d btn=%b v=%b drop=%0d, want all zero",
                     x_pos_o, y_pos_o, buttons_o, pos_valid_o, drop_cnt_o);
        end
    endtask

    task automatic test_basic();
        send_packet(8'h09, 8'h0A, 8'h00);
        // One edge after the last byte the FSM is only in APPLY.
        n_cmp++;
        if (pos_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_latency: got v=%b, want v=0", pos_valid_o);
        end
        @(negedge clk_i);
        e = sb.pop_front();
        n_cmp++;
        if ({x_pos_o, y_pos_o, buttons_o, pos_valid_o} !== {PW'(e.x), PW'(e.y), e.b, 1'b1}) begin
            n_bad++;
            $display("FAIL basic_update: got x=%0d y=%0d btn=%b v=%b, want x=%0d y=%0d btn=%b v=1",
                     x_pos_o, y_pos_o, buttons_o, pos_valid_o, e.x, e.y, e.b);
        end
    endtask

    task automatic test_clamp_low_and_ack();
        send_packet(8'h38, 8'hF0, 8'hF6);
        @(negedge clk_i);
        e = sb.pop_front();
        n_cmp++;
        if ({x_pos_o, y_pos_o, buttons_o, pos_valid_o} !== {PW'(e.x), PW'(e.y), e.b, 1'b1}) begin
            n_bad++;
            $display("FAIL clamp_low: got x=%0d y=%0d btn=%b v=%b, want x=%0d y=%0d btn=%b v=1",
                     x_pos_o, y_pos_o, buttons_o, pos_valid_o, e.x, e.y, e.b);
        end
        pulse_ack();
        n_cmp++;
        if (pos_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL ack_clear: got v=%b, want v=0", pos_valid_o);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 50; i++) begin
            send_packet(8'h08, 8'h7F, 8'h00);
            @(negedge clk_i);
            e = sb.pop_front();
            n_cmp++;
            if ({x_pos_o, y_pos_o, buttons_o, pos_valid_o} !== {PW'(e.x), PW'(e.y), e.b, 1'b1}) begin
                n_bad++;
                $display("FAIL saturate_%0d: got x=%0d y=%0d btn=%b v=%b, want x=%0d y=%0d btn=%b v=1",
                         i, x_pos_o, y_pos_o, buttons_o, pos_valid_o, e.x, e.y, e.b);
            end
        end
        pulse_ack();
        send_packet(8'h48, 8'h7F, 8'h00);
        @(negedge clk_i);
        e = sb.pop_front();
        n_cmp++;
        if ({x_pos_o, y_pos_o, buttons_o, pos_valid_o} !== {PW'(e.x), PW'(e.y), e.b, 1'b1}) begin
            n_bad++;
            $display("FAIL x_overflow: got x=%0d y=%0d btn=%b v=%b, want x=%0d y=%0d btn=%b v=1",
                     x_pos_o, y_pos_o, buttons_o, pos_valid_o, e.x, e.y, e.b);
        end
    endtask

    task automatic test_resync();
        do_reset();
        send_byte(8'h00, 2);
        exp_drop++;
        send_packet(8'h2C, 8'h02, 8'hFD);
        @(negedge clk_i);
        e = sb.pop_front();
        n_cmp++;
        if ({x_pos_o, y_pos_o, buttons_o, pos_valid_o} !== {PW'(e.x), PW'(e.y), e.b, 1'b1}) begin
            n_bad++;
            $display("FAIL resync_update: got x=%0d y=%0d btn=%b v=%b, want x=%0d y=%0d btn=%b v=1",
                     x_pos_o, y_pos_o, buttons_o, pos_valid_o, e.x, e.y, e.b);
        end
        n_cmp++;
        if (drop_cnt_o !== 8'(exp_drop)) begin
            n_bad++;
            $display("FAIL resync_drop: got %0d, want %0d", drop_cnt_o, exp_drop);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        // Gaps just below the limit must not abort.
        model_packet(8'h08, 8'h01, 8'h01);
        send_byte(8'h08, TO - 4);
        send_byte(8'h01, TO - 4);
        send_byte(8'h01, 0);
        @(negedge clk_i);
        e = sb.pop_front();
        n_cmp++;
        if ({x_pos_o, y_pos_o, buttons_o, pos_valid_o} !== {PW'(e.x), PW'(e.y), e.b, 1'b1}) begin
            n_bad++;
            $display("FAIL near_timeout: got x=%0d y=%0d btn=%b v=%b, want x=%0d y=%0d btn=%b v=1",
                     x_pos_o, y_pos_o, buttons_o, pos_valid_o, e.x, e.y, e.b);
        end
        pulse_ack();
        send_byte(8'h08, 2);
        send_byte(8'h05, TO + 4);
        exp_drop++;
        n_cmp++;
        if ({drop_cnt_o, pos_valid_o, x_pos_o} !== {8'(exp_drop), 1'b0, PW'(mx)}) begin
            n_bad++;
            $display("FAIL timeout_abort: got drop=%0d v=%b x=%0d, want drop=%0d v=0 x=%0d",
                     drop_cnt_o, pos_valid_o, x_pos_o, exp_drop, mx);
        end
        send_packet(8'h08, 8'h01, 8'h01);
        @(negedge clk_i);
        e = sb.pop_front();
        n_cmp++;
        if ({x_pos_o, y_pos_o, buttons_o, pos_valid_o} !== {PW'(e.x), PW'(e.y), e.b, 1'b1}) begin
            n_bad++;
            $display("FAIL after_timeout: got x=%0d y=%0d btn=%b v=%b, want x=%0d y=%0d btn=%b v=1",
                     x_pos_o, y_pos_o, buttons_o, pos_valid_o, e.x, e.y, e.b);
        end
    endtask

    task automatic test_rx_err();
        do_reset();
        send_byte(8'h08, 2);
        send_byte(8'h05, 1);
        @(negedge clk_i);
        rx_err_i = 1'b1;
        @(negedge clk_i);
        rx_err_i = 1'b0;
        exp_drop++;
        n_cmp++;
        if ({drop_cnt_o, pos_valid_o, x_pos_o, y_pos_o} !== {8'(exp_drop), 1'b0, PW'(0), PW'(0)}) begin
            n_bad++;
            $display("FAIL err_abort: got drop=%0d v=%b x=%0d y=%0d, want drop=%0d v=0 x=0 y=0",
                     drop_cnt_o, pos_valid_o, x_pos_o, y_pos_o, exp_drop);
        end
        // Byte and error together: the byte must not start a packet.
        @(negedge clk_i);
        rx_valid_i = 1'b1;
        rx_data_i  = 8'h08;
        rx_err_i   = 1'b1;
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        rx_err_i   = 1'b0;
        exp_drop++;
        send_packet(8'h09, 8'h03, 8'h00);
        @(negedge clk_i);
        e = sb.pop_front();
        n_cmp++;
        if ({x_pos_o, y_pos_o, buttons_o, pos_valid_o} !== {PW'(e.x), PW'(e.y), e.b, 1'b1}) begin
            n_bad++;
            $display("FAIL err_then_packet: got x=%0d y=%0d btn=%b v=%b, want x=%0d y=%0d btn=%b v=1",
                     x_pos_o, y_pos_o, buttons_o, pos_valid_o, e.x, e.y, e.b);
        end
        n_cmp++;
        if (drop_cnt_o !== 8'(exp_drop)) begin
            n_bad++;
            $display("FAIL err_drop: got %0d, want %0d", drop_cnt_o, exp_drop);
        end
    endtask

    task automatic test_back_to_back();
        pulse_ack();
        model_packet(8'h08, 8'h04, 8'h00);
        send_byte(8'h08, 2);
        send_byte(8'h04, 2);
        @(negedge clk_i);
        rx_valid_i = 1'b1;
        rx_data_i  = 8'h00;
        @(negedge clk_i);
        // APPLY cycle: a stray byte and an ack arrive together.
        rx_data_i = 8'h08;
        ack_i     = 1'b1;
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        ack_i      = 1'b0;
        exp_drop++;
        e = sb.pop_front();
        n_cmp++;
        if ({x_pos_o, y_pos_o, buttons_o, pos_valid_o} !== {PW'(e.x), PW'(e.y), e.b, 1'b1}) begin
            n_bad++;
            $display("FAIL apply_ack: got x=%0d y=%0d btn=%b v=%b, want x=%0d y=%0d btn=%b v=1",
                     x_pos_o, y_pos_o, buttons_o, pos_valid_o, e.x, e.y, e.b);
        end
        n_cmp++;
        if (drop_cnt_o !== 8'(exp_drop)) begin
            n_bad++;
            $display("FAIL apply_drop: got %0d, want %0d", drop_cnt_o, exp_drop);
        end
        send_packet(8'h0A, 8'h01, 8'h00);
        @(negedge clk_i);
        e = sb.pop_front();
        n_cmp++;
        if ({x_pos_o, y_pos_o, buttons_o, pos_valid_o} !== {PW'(e.x), PW'(e.y), e.b, 1'b1}) begin
            n_bad++;
            $display("FAIL back_to_back: got x=%0d y=%0d btn=%b v=%b, want x=%0d y=%0d btn=%b v=1",
                     x_pos_o, y_pos_o, buttons_o, pos_valid_o, e.x, e.y, e.b);
        end
    endtask

    task automatic test_reset_mid_packet();
        send_byte(8'h09, 2);
        send_byte(8'h05, 2);
        @(negedge clk_i);
        rstn_i = 1'b0;
        #1;
        n_cmp++;
        if ({x_pos_o, y_pos_o, buttons_o, pos_valid_o, drop_cnt_o} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got x=%0d y=%0d btn=%b v=%b drop=%0d, want all zero",
                     x_pos_o, y_pos_o, buttons_o, pos_valid_o, drop_cnt_o);
        end
        @(negedge clk_i);
        rstn_i   = 1'b1;
        mx       = 0;
        my       = 0;
        exp_drop = 0;
        // A non-status byte must be dropped: the partial packet is gone.
        send_byte(8'h00, 2);
        exp_drop++;
        n_cmp++;
        if ({drop_cnt_o, pos_valid_o, x_pos_o} !== {8'(exp_drop), 1'b0, PW'(0)}) begin
            n_bad++;
            $display("FAIL reset_no_partial: got drop=%0d v=%b x=%0d, want drop=%0d v=0 x=0",
                     drop_cnt_o, pos_valid_o, x_pos_o, exp_drop);
        end
        send_packet(8'h09, 8'h01, 8'h00);
        @(negedge clk_i);
        e = sb.pop_front();
        n_cmp++;
        if ({x_pos_o, y_pos_o, buttons_o, pos_valid_o} !== {PW'(e.x), PW'(e.y), e.b, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_recover: got x=%0d y=%0d btn=%b v=%b, want x=%0d y=%0d btn=%b v=1",
                     x_pos_o, y_pos_o, buttons_o, pos_valid_o, e.x, e.y, e.b);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp_low_and_ack();
        test_saturate();
        test_resync();
        test_timeout();
        test_rx_err();
        test_back_to_back();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_packet_decoder.md
# ps2_mouse_packet_decoder

Assembles the byte stream from the PS/2 receiver into standard 3-byte mouse packets. It accumulates signed X/Y movement into clamped absolute screen coordinates and latches button state. It sits between the PS/2 byte receiver and the mouse APB register block. The APB block reads `x_pos_o`/`y_pos_o`/`buttons_o` and pulses `ack_i` once software has consumed an update.

## Interface
- `POS_WIDTH`, default 10: width of each coordinate output.
- `X_MAX`, default 639: largest X coordinate; X is clamped to [0, X_MAX].
- `Y_MAX`, default 479: largest Y coordinate; Y is clamped to [0, Y_MAX].
- `TIMEOUT_CYCLES`, default 100000: maximum idle gap between bytes of one packet.
- `clk_i`  in  1  clock.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `rx_valid_i`  in  1  one-cycle strobe; `rx_data_i` holds a received byte.
- `rx_data_i`  in  8  received byte.
- `rx_err_i`  in  1  one-cycle strobe; receiver detected a parity or framing error.
- `ack_i`  in  1  one-cycle strobe; clears `pos_valid_o`.
- `x_pos_o`  out  POS_WIDTH  absolute X coordinate.
- `y_pos_o`  out  POS_WIDTH  absolute Y coordinate (0 = top of screen).
- `buttons_o`  out  3  {middle, right, left} from the last accepted packet.
- `pos_valid_o`  out  1  sticky flag: a new packet has been applied since the last ack.
- `drop_cnt_o`  out  8  saturating count of discarded packets or bytes.

## Operation
- FSM states: `WAIT_B0`, `WAIT_B1`, `WAIT_B2`, `APPLY`. Reset state is `WAIT_B0`.
- `WAIT_B0`: on `rx_valid_i`:
  - If `rx_data_i[3]` is 1, capture the byte as the status byte and go to `WAIT_B1`.
  - Otherwise discard the byte, increment `drop_cnt_o`, and stay in `WAIT_B0` (resynchronisation).
- Status byte layout: bit0 L, bit1 R, bit2 M, bit3 always 1, bit4 X sign, bit5 Y sign, bit6 X overflow, bit7 Y overflow.
- `WAIT_B1`: on `rx_valid_i`, capture dx and go to `WAIT_B2`.
- `WAIT_B2`: on `rx_valid_i`, capture dy and go to `APPLY`.
- `APPLY`: lasts one cycle, then always returns to `WAIT_B0`. In this cycle:
  - Deltas are 9-bit signed values: {sign, byte}, range −256..+255.
  - If an axis overflow bit is set, that axis delta is treated as 0.
  - Next X = clamp(x + dx, 0, X_MAX).
  - Next Y = clamp(y − dy, 0, Y_MAX). PS/2 +Y means up.
  - Sums are computed at POS_WIDTH+2 bits signed, so no intermediate wrap is possible.
  - `buttons_o` is updated from the status byte.
  - `pos_valid_o` is set.
- Abort (go to `WAIT_B0`, discard the partial packet, increment `drop_cnt_o`) when either:
  - `rx_err_i` arrives in `WAIT_B1` or `WAIT_B2`, or
  - the inter-byte gap counter reaches TIMEOUT_CYCLES in `WAIT_B1` or `WAIT_B2`.
- `rx_err_i` in `WAIT_B0` increments `drop_cnt_o` only.
- The gap counter resets on every accepted byte and on entry to `WAIT_B0`.
- `rx_valid_i` and `rx_err_i` in the same cycle: the error wins and the byte is ignored.
- `rx_valid_i` during `APPLY` is ignored and counted as a drop. The receiver cannot produce bytes that fast, so this is a protocol error.
- `drop_cnt_o` saturates at 255 and is cleared only by reset.

## Timing
- Reset values:
  - `x_pos_o` = 0, `y_pos_o` = 0
  - `buttons_o` = 0, `pos_valid_o` = 0, `drop_cnt_o` = 0
  - FSM = `WAIT_B0`, gap counter = 0
- All outputs are registered.
- Latency: the third byte is accepted at edge N. The FSM is in `APPLY` during cycle N+1. New position, buttons and `pos_valid_o` = 1 are visible after edge N+1.
- `ack_i` clears `pos_valid_o` on the next edge.
- `ack_i` in the same cycle as `APPLY`: the set wins and `pos_valid_o` stays 1.
- Position updates are never blocked by an unacknowledged `pos_valid_o`; the newest value overwrites the old one.
- Asserting reset mid-packet immediately returns every register to its reset value. No partial update is retained.

## Structure
- Shared package `mouse_pkg` holds:
  - the state enum `mouse_state_e`;
  - the status-byte bit index constants (`MB_LEFT`, `MB_RIGHT`, `MB_MIDDLE`, `MB_ALWAYS1`, `MB_XSIGN`, `MB_YSIGN`, `MB_XOVF`, `MB_YOVF`);
  - the default `X_MAX`/`Y_MAX`.
- Sub-module `ps2_mouse_axis_acc`: one axis of sign-extend, overflow mask, add/subtract and clamp, with parameters POS_WIDTH and MAX.
  - Instantiated twice: X with add, Y with subtract.

## Test plan
- Reset, then bytes 0x09, 0x0A, 0x00 → `x_pos_o` = 10, `y_pos_o` = 0, `buttons_o` = 3'b001, `pos_valid_o` = 1 two cycles after the last byte.
- From (10,0), bytes 0x38, 0xF0, 0xF6 (dx = −16, dy = −10) → X clamps to 0, Y = 10. Then `ack_i` → `pos_valid_o` = 0 next cycle.
- Fifty packets of 0x08, 0x7F, 0x00 → X saturates at 639 with no wrap. Packet 0x48, 0x7F, 0x00 (X overflow set) → X unchanged and `pos_valid_o` set.
- Byte 0x00 arrives first, then a valid packet → `drop_cnt_o` = 1 and the packet is applied normally.
- Bytes 0x08, 0x05, then TIMEOUT_CYCLES of idle, then 0x08, 0x01, 0x01 → `drop_cnt_o` = 1, X += 1, Y −= 1 (clamped).
- Bytes 0x08, 0x05, then `rx_err_i` → no update and `drop_cnt_o` = 1. Assert `rstn_i` mid-packet → all outputs return to 0.
